sfx_arbiter: RTL and testbench

SFX_ARBITER -- requirements
Module: sfx_arbiter

---
 rtl/sfx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sfx_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: queues four prioritised effect requests and plays each as a square-wave note sequence.
// Optional SFX_ENVELOPE_EN adds a linear decay envelope to the note amplitude.
module sfx_arbiter #(
  parameter int SAMPLE_DIV = 2500,
  parameter int DUR_UNIT   = 256,
  parameter int AMP        = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        req,
  output logic [3:0]        ack,
  output logic              busy,
  output logic [1:0]        active_id,
  output logic signed [7:0] audio_sample
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, NEXT = 2'd3} state_t;

  localparam logic [15:0]        DIV_LAST   = 16'(SAMPLE_DIV - 1);
  localparam logic [23:0]        DUR_UNIT_W = 24'(DUR_UNIT);
  localparam logic signed [7:0]  AMP_S      = 8'(AMP);

  // {half_period, dur} indexed by {effect, note}; half_period 0 ends the effect
  localparam logic [15:0] NOTE_ROM [16] = '{
    {8'd20, 8'd2}, {8'd15, 8'd2}, 16'd0,         16'd0,
    {8'd40, 8'd4}, 16'd0,         16'd0,         16'd0,
    {8'd10, 8'd1}, {8'd12, 8'd1}, {8'd14, 8'd1}, {8'd16, 8'd1},
    {8'd60, 8'd8}, {8'd80, 8'd8}, 16'd0,         16'd0
  };

`ifdef SFX_ENVELOPE_EN
  function automatic logic signed [7:0] env_amp(input logic [23:0] ticks);
    logic [23:0] dec;
    dec = ticks >> 2;
    if (dec >= 24'(AMP)) return 8'sd0;
    else                 return AMP_S - $signed(dec[7:0]);
  endfunction
`endif

  state_t             state, state_nxt;
  logic [3:0]         pend;
  logic [1:0]         sel_id;
  logic [3:0]         sel_oh;
  logic [3:0]         higher_mask;
  logic               preempt;
  logic [15:0]        div_cnt;
  logic               tick;
  logic [1:0]         note_idx;
  logic [1:0]         idx_inc;
  logic [7:0]         phase;
  logic               pol;
  logic [23:0]        dur_cnt;
  logic [23:0]        dur_total;
  logic [7:0]         load_hp, cur_hp, cur_dur, next_hp;
  logic               note_done;
  logic               phase_wrap;
  logic signed [7:0]  amp_cur;

  assign tick       = (div_cnt == DIV_LAST);
  assign idx_inc    = note_idx + 2'd1;
  assign load_hp    = NOTE_ROM[{sel_id, 2'd0}][15:8];
  assign cur_hp     = NOTE_ROM[{active_id, note_idx}][15:8];
  assign cur_dur    = NOTE_ROM[{active_id, note_idx}][7:0];
  assign next_hp    = NOTE_ROM[{active_id, idx_inc}][15:8];
  assign dur_total  = {16'd0, cur_dur} * DUR_UNIT_W;
  assign note_done  = tick && (dur_cnt == dur_total - 24'd1);
  assign phase_wrap = (phase == cur_hp - 8'd1);
  assign preempt    = |(pend & higher_mask);

`ifdef SFX_ENVELOPE_EN
  assign amp_cur = env_amp(dur_cnt);
`else
  assign amp_cur = AMP_S;
`endif

  always_comb begin
    sel_id = 2'd0;
    sel_oh = 4'b0000;
    if (pend[3])      begin sel_id = 2'd3; sel_oh = 4'b1000; end
    else if (pend[2]) begin sel_id = 2'd2; sel_oh = 4'b0100; end
    else if (pend[1]) begin sel_id = 2'd1; sel_oh = 4'b0010; end
    else if (pend[0]) begin sel_id = 2'd0; sel_oh = 4'b0001; end
  end

  always_comb begin
    case (active_id)
      2'd0:    higher_mask = 4'b1110;
      2'd1:    higher_mask = 4'b1100;
      2'd2:    higher_mask = 4'b1000;
      default: higher_mask = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pend != 4'b0000) state_nxt = LOAD;
      LOAD: state_nxt = (load_hp != 8'd0) ? PLAY : IDLE;
      PLAY: begin
        if (preempt)        state_nxt = LOAD;
        else if (note_done) state_nxt = NEXT;
      end
      NEXT: begin
        if (preempt)                                state_nxt = LOAD;
        else if (note_idx == 2'd3 || next_hp == 8'd0) state_nxt = IDLE;
        else                                        state_nxt = PLAY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack  = (state == LOAD) ? sel_oh : 4'b0000;
    busy = (state != IDLE);
  end

  // Divider runs freely; note counters restart on every PLAY entry
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt      <= '0;
      pend         <= '0;
      active_id    <= '0;
      note_idx     <= '0;
      phase        <= '0;
      pol          <= 1'b0;
      dur_cnt      <= '0;
      audio_sample <= '0;
    end else begin
      div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
      pend    <= (pend | req) & ~ack;
      case (state)
        LOAD: begin
          active_id <= sel_id;
          note_idx  <= 2'd0;
          phase     <= 8'd0;
          dur_cnt   <= 24'd0;
          pol       <= 1'b1;
        end
        PLAY: if (tick) begin
          phase   <= phase_wrap ? 8'd0 : phase + 8'd1;
          pol     <= phase_wrap ? ~pol : pol;
          dur_cnt <= dur_cnt + 24'd1;
        end
        NEXT: begin
          note_idx <= idx_inc;
          phase    <= 8'd0;
          dur_cnt  <= 24'd0;
          pol      <= 1'b1;
        end
        default: ;
      endcase
      if (state == PLAY) audio_sample <= pol ? amp_cur : -amp_cur;
      else               audio_sample <= 8'sd0;
    end
  end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter: priority, preemption, absorption, replay, reset abort and square-wave timing.
module tb_sfx_arbiter;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [3:0]        req, req2;
  logic [3:0]        ack, ack2;
  logic              busy, busy2;
  logic [1:0]        active_id, active_id2;
  logic signed [7:0] audio_sample, audio2;

  int n_chk  = 0;
  int n_pass = 0;

  sfx_arbiter #(.SAMPLE_DIV(4), .DUR_UNIT(4), .AMP(64)) u_dut (
    .CLK(CLK), .RESET(RESET), .req(req), .ack(ack), .busy(busy),
    .active_id(active_id), .audio_sample(audio_sample)
  );

  // Longer notes so the square wave actually alternates within one note
  sfx_arbiter #(.SAMPLE_DIV(2), .DUR_UNIT(16), .AMP(64)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .req(req2), .ack(ack2), .busy(busy2),
    .active_id(active_id2), .audio_sample(audio2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic pulse(input logic [3:0] v);
    @(negedge CLK); req = v;
    @(negedge CLK); req = 4'b0000;
  endtask

  task automatic run(input int n, output int acks, output int idle_cyc);
    acks = 0; idle_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (ack != 4'b0000) acks++;
      if (!busy) idle_cyc++;
    end
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] a, output int cyc, output int idle_cyc);
    a = 4'b0000; cyc = 0; idle_cyc = 0;
    while (cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if (!busy) idle_cyc++;
      if (ack != 4'b0000) begin a = ack; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output int cyc, output int acks);
    cyc = 0; acks = 0;
    while (cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if (ack != 4'b0000) acks++;
      if (!busy) break;
    end
  endtask

  task automatic neg_run2(input int budget, output int len);
    int waited;
    waited = 0; len = 0;
    while (audio2 != -8'sd64 && waited < budget) begin
      @(negedge CLK); waited++;
    end
    while (audio2 == -8'sd64 && len < budget) begin
      @(negedge CLK); len++;
    end
  endtask

  initial begin
    int acks, idle_cyc, cyc, len;
    logic [3:0] a;
    RESET = 1'b1; req = 4'b0000; req2 = 4'b0000;
    repeat (3) @(negedge CLK);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_ack",   int'(ack), 0);
    chk("rst_audio", int'(audio_sample), 0);
    chk("rst_id",    int'(active_id), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Single E0 request: ack two cycles after the pulse, positive square, then idle
    pulse(4'b0001);
    @(negedge CLK);
    chk("e0_ack", int'(ack), 4'b0001);
    chk("e0_busy", int'(busy), 1);
    @(negedge CLK);
    chk("e0_ack_1cyc", int'(ack), 0);
    chk("e0_id", int'(active_id), 0);
    run(10, acks, idle_cyc);
    chk("e0_audio_pos", int'(audio_sample), 64);
    wait_idle(300, cyc, acks);
    len = 11 + cyc;
    chk($sformatf("e0_len(%0d)", len), int'(len >= 61 && len <= 67), 1);
    chk("e0_idle_audio", int'(audio_sample), 0);
    chk("e0_no_extra_ack", acks, 0);

    // Simultaneous E0+E1: E1 first, E0 after one idle cycle
    pulse(4'b0011);
    @(negedge CLK);
    chk("pri_ack_e1", int'(ack), 4'b0010);
    @(negedge CLK);
    chk("pri_id_e1", int'(active_id), 1);
    wait_ack(400, a, cyc, idle_cyc);
    chk("pri_ack_e0", int'(a), 4'b0001);
    chk("pri_gap", idle_cyc, 1);
    @(negedge CLK);
    chk("pri_id_e0", int'(active_id), 0);
    wait_idle(300, cyc, acks);
    chk("pri_done", int'(busy), 0);

    // E3 preempts a playing E0; E0 is dropped
    pulse(4'b0001);
    @(negedge CLK);
    chk("pre_ack_e0", int'(ack), 4'b0001);
    run(10, acks, idle_cyc);
    pulse(4'b1000);
    @(negedge CLK);
    chk("pre_ack_e3", int'(ack), 4'b1000);
    @(negedge CLK);
    chk("pre_id", int'(active_id), 3);
    wait_idle(700, cyc, acks);
    chk("pre_e3_done", int'(busy), 0);
    chk("pre_no_ack", acks, 0);
    run(10, acks, idle_cyc);
    chk("pre_no_requeue", acks, 0);
    chk("pre_idle", idle_cyc, 10);

    // Re-request of E2 while playing waits and replays afterwards
    pulse(4'b0100);
    @(negedge CLK);
    chk("rep_ack1", int'(ack), 4'b0100);
    run(6, acks, idle_cyc);
    pulse(4'b0100);
    wait_ack(400, a, cyc, idle_cyc);
    chk("rep_ack2", int'(a), 4'b0100);
    chk("rep_gap", idle_cyc, 1);
    chk($sformatf("rep_late(%0d)", cyc), int'(cyc >= 40), 1);
    wait_idle(300, cyc, acks);
    run(10, acks, idle_cyc);
    chk("rep_once", acks, 0);

    // req held through LOAD is absorbed by the ack
    @(negedge CLK); req = 4'b0010;
    @(negedge CLK);
    @(negedge CLK);
    chk("abs_ack", int'(ack), 4'b0010);
    @(negedge CLK); req = 4'b0000;
    wait_idle(300, cyc, acks);
    run(10, acks, idle_cyc);
    chk("abs_no_second", acks, 0);

    // Reset mid-E3 with E0 pending
    pulse(4'b1000);
    @(negedge CLK);
    chk("rst3_ack", int'(ack), 4'b1000);
    run(20, acks, idle_cyc);
    pulse(4'b0001);
    run(3, acks, idle_cyc);
    chk("rst3_waits", acks, 0);
    #2 RESET = 1'b1;
    #1;
    chk("rst3_busy",  int'(busy), 0);
    chk("rst3_ack0",  int'(ack), 0);
    chk("rst3_audio", int'(audio_sample), 0);
    chk("rst3_id",    int'(active_id), 0);
    @(negedge CLK); RESET = 1'b0;
    run(20, acks, idle_cyc);
    chk("rst3_no_ack", acks, 0);
    chk("rst3_idle", idle_cyc, 20);

    // Polarity: E0 note0 low for 12 ticks, note1 low for 15 ticks (2 cycles per tick)
    @(negedge CLK); req2 = 4'b0001;
    @(negedge CLK); req2 = 4'b0000;
    @(negedge CLK);
    chk("pol_ack", int'(ack2), 4'b0001);
    neg_run2(200, len);
    chk("pol_low_n0", len, 24);
    neg_run2(200, len);
    chk("pol_low_n1", len, 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
